// File: rtl/fetch_unit_pkg.sv
// Shared types and default sizes for the fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    localparam int PC_W   = 10;
    localparam int LUT_AW = 5;
    localparam int CNT_W  = 16;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Writable table of absolute branch targets: one synchronous write port and one combinational read port.
module branch_lut #(
    parameter int AW = 5,
    parameter int DW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wrEn,
    input  logic [AW-1:0] i_wrAddr,
    input  logic [DW-1:0] i_wrData,
    input  logic [AW-1:0] i_rdAddr,
    output logic [DW-1:0] o_rdData
);

    logic [DW-1:0] r_table [2**AW];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                r_table[i] <= '0;
            end
        end else if (i_wrEn) begin
            r_table[i_wrAddr] <= i_wrData;
        end
    end

    // The read returns the value stored before any same-cycle write lands.
    assign o_rdData = r_table[i_rdAddr];

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: start load, sequential advance, LUT-based branches, halt.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W   = fetch_unit_pkg::PC_W,
    parameter int LUT_AW = fetch_unit_pkg::LUT_AW,
    parameter int CNT_W  = fetch_unit_pkg::CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PC_W-1:0]   StartAddr,
    input  logic              Ack,
    input  logic              BranchEn,
    input  logic              BranchTaken,
    input  logic [LUT_AW-1:0] BranchIdx,
    input  logic              Stall,
    input  logic              LutWrEn,
    input  logic [LUT_AW-1:0] LutWrAddr,
    input  logic [PC_W-1:0]   LutWrData,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Fetching,
    output logic              Done,
    output logic              PcWrap,
    output logic [CNT_W-1:0]  CycleCnt
);

    fetch_state_t    r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_cycleCnt;
    logic             r_pcWrap;
    logic [PC_W-1:0]  w_lutTarget;

    branch_lut #(
        .AW (LUT_AW),
        .DW (PC_W)
    ) u_lut (
        .i_clk    (Clk),
        .i_rst_n  (Reset),
        .i_wrEn   (LutWrEn),
        .i_wrAddr (LutWrAddr),
        .i_wrData (LutWrData),
        .i_rdAddr (BranchIdx),
        .o_rdData (w_lutTarget)
    );

    // Start overrides everything; within RUN, Ack beats Stall which beats a taken branch.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_cycleCnt <= '0;
            r_pcWrap   <= 1'b0;
        end else begin
            r_pcWrap <= 1'b0;
            if (Start) begin
                r_state    <= LOAD;
                r_pc       <= StartAddr;
                r_cycleCnt <= '0;
            end else begin
                case (r_state)
                    IDLE: r_state <= IDLE;
                    LOAD: r_state <= RUN;
                    RUN: begin
                        if (r_cycleCnt != {CNT_W{1'b1}}) begin
                            r_cycleCnt <= r_cycleCnt + CNT_W'(1);
                        end
                        if (Ack) begin
                            r_state <= HALT;
                        end else if (Stall) begin
                            r_pc <= r_pc;
                        end else if (BranchEn && BranchTaken) begin
                            r_pc <= w_lutTarget;
                        end else begin
                            r_pc     <= r_pc + PC_W'(1);
                            r_pcWrap <= (r_pc == {PC_W{1'b1}});
                        end
                    end
                    HALT: r_state <= HALT;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign ProgCtr  = r_pc;
    assign CycleCnt = r_cycleCnt;
    assign PcWrap   = r_pcWrap;
    assign Fetching = (r_state == RUN);
    assign Done     = (r_state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [9:0]  StartAddr = '0;
    logic        Ack = 1'b0;
    logic        BranchEn = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [4:0]  BranchIdx = '0;
    logic        Stall = 1'b0;
    logic        LutWrEn = 1'b0;
    logic [4:0]  LutWrAddr = '0;
    logic [9:0]  LutWrData = '0;
    logic [9:0]  ProgCtr;
    logic        Fetching;
    logic        Done;
    logic        PcWrap;
    logic [15:0] CycleCnt;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .StartAddr   (StartAddr),
        .Ack         (Ack),
        .BranchEn    (BranchEn),
        .BranchTaken (BranchTaken),
        .BranchIdx   (BranchIdx),
        .Stall       (Stall),
        .LutWrEn     (LutWrEn),
        .LutWrAddr   (LutWrAddr),
        .LutWrData   (LutWrData),
        .ProgCtr     (ProgCtr),
        .Fetching    (Fetching),
        .Done        (Done),
        .PcWrap      (PcWrap),
        .CycleCnt    (CycleCnt)
    );

    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clearInputs();
        Start = 0; Ack = 0; BranchEn = 0; BranchTaken = 0; BranchIdx = '0;
        Stall = 0; LutWrEn = 0; LutWrAddr = '0; LutWrData = '0;
    endtask

    task automatic startAt(input logic [9:0] addr);
        Start = 1; StartAddr = addr;
        tick();
        Start = 0;
        tick();
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ProgCtr !== 10'h000) begin errors++; $display("[TB] FAIL reset_pc got %h expected %h", ProgCtr, 10'h000); end
        checks++; if (Fetching !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetching got %b expected 0", Fetching); end
        checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", Done); end
        checks++; if (PcWrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap got %b expected 0", PcWrap); end
        checks++; if (CycleCnt !== 16'h0000) begin errors++; $display("[TB] FAIL reset_cnt got %h expected 0000", CycleCnt); end
        Reset = 1;
        tick();
        checks++; if (Fetching !== 1'b0 || ProgCtr !== 10'h000) begin errors++; $display("[TB] FAIL idle_hold got fetch=%b pc=%h expected fetch=0 pc=000", Fetching, ProgCtr); end
    endtask

    task automatic test_start_run();
        Start = 1; StartAddr = 10'h010;
        repeat (3) tick();
        checks++; if (ProgCtr !== 10'h010 || Fetching !== 1'b0 || Done !== 1'b0) begin errors++; $display("[TB] FAIL load_state got pc=%h fetch=%b done=%b expected pc=010 fetch=0 done=0", ProgCtr, Fetching, Done); end
        Start = 0;
        tick();
        checks++; if (ProgCtr !== 10'h010 || Fetching !== 1'b1) begin errors++; $display("[TB] FAIL run_first got pc=%h fetch=%b expected pc=010 fetch=1", ProgCtr, Fetching); end
        checks++; if (CycleCnt !== 16'd0) begin errors++; $display("[TB] FAIL run_first_cnt got %0d expected 0", CycleCnt); end
        tick();
        checks++; if (ProgCtr !== 10'h011) begin errors++; $display("[TB] FAIL run_seq1 got %h expected 011", ProgCtr); end
        tick();
        checks++; if (ProgCtr !== 10'h012 || CycleCnt !== 16'd2) begin errors++; $display("[TB] FAIL run_seq2 got pc=%h cnt=%0d expected pc=012 cnt=2", ProgCtr, CycleCnt); end
    endtask

    task automatic test_branch();
        LutWrEn = 1; LutWrAddr = 5'd5; LutWrData = 10'h123;
        tick();
        LutWrEn = 0;
        startAt(10'h020);
        BranchEn = 1; BranchTaken = 1; BranchIdx = 5'd5;
        tick();
        checks++; if (ProgCtr !== 10'h123) begin errors++; $display("[TB] FAIL branch_taken got %h expected 123", ProgCtr); end
        clearInputs();
        startAt(10'h020);
        BranchEn = 1; BranchTaken = 0; BranchIdx = 5'd5;
        tick();
        checks++; if (ProgCtr !== 10'h021) begin errors++; $display("[TB] FAIL branch_not_taken got %h expected 021", ProgCtr); end
        BranchEn = 0; BranchTaken = 1;
        tick();
        checks++; if (ProgCtr !== 10'h022) begin errors++; $display("[TB] FAIL taken_without_en got %h expected 022", ProgCtr); end
        clearInputs();
    endtask

    task automatic test_ack_halt();
        startAt(10'h030);
        Ack = 1; BranchEn = 1; BranchTaken = 1; BranchIdx = 5'd5; Stall = 1;
        tick();
        checks++; if (Done !== 1'b1 || Fetching !== 1'b0 || ProgCtr !== 10'h030) begin errors++; $display("[TB] FAIL ack_halt got done=%b fetch=%b pc=%h expected done=1 fetch=0 pc=030", Done, Fetching, ProgCtr); end
        checks++; if (CycleCnt !== 16'd1) begin errors++; $display("[TB] FAIL ack_cnt got %0d expected 1", CycleCnt); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (Done !== 1'b1 || ProgCtr !== 10'h030 || CycleCnt !== 16'd1) begin errors++; $display("[TB] FAIL halt_hold[%0d] got done=%b pc=%h cnt=%0d expected done=1 pc=030 cnt=1", i, Done, ProgCtr, CycleCnt); end
        end
        clearInputs();
        Start = 1; StartAddr = 10'h040;
        tick();
        checks++; if (Done !== 1'b0 || Fetching !== 1'b0 || ProgCtr !== 10'h040 || CycleCnt !== 16'd0) begin errors++; $display("[TB] FAIL halt_restart got done=%b fetch=%b pc=%h cnt=%0d expected done=0 fetch=0 pc=040 cnt=0", Done, Fetching, ProgCtr, CycleCnt); end
        Start = 0;
    endtask

    task automatic test_stall();
        tick();
        Stall = 1;
        repeat (4) tick();
        checks++; if (ProgCtr !== 10'h040 || CycleCnt !== 16'd4) begin errors++; $display("[TB] FAIL stall_hold got pc=%h cnt=%0d expected pc=040 cnt=4", ProgCtr, CycleCnt); end
        Stall = 0;
        tick();
        checks++; if (ProgCtr !== 10'h041 || CycleCnt !== 16'd5) begin errors++; $display("[TB] FAIL stall_release got pc=%h cnt=%0d expected pc=041 cnt=5", ProgCtr, CycleCnt); end
    endtask

    task automatic test_wrap();
        logic [9:0] expPc [4];
        logic       expWrap [4];
        int         pulses;
        expPc = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        expWrap = '{1'b0, 1'b0, 1'b1, 1'b0};
        pulses = 0;
        Start = 1; StartAddr = 10'h3FE;
        tick();
        Start = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (PcWrap === 1'b1) pulses++;
            checks++; if (ProgCtr !== expPc[i] || PcWrap !== expWrap[i]) begin errors++; $display("[TB] FAIL wrap_seq[%0d] got pc=%h wrap=%b expected pc=%h wrap=%b", i, ProgCtr, PcWrap, expPc[i], expWrap[i]); end
        end
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL wrap_pulses got %0d expected 1", pulses); end
        // A branch from the top address to 0 must not flag a wrap.
        startAt(10'h3FF);
        BranchEn = 1; BranchTaken = 1; BranchIdx = 5'd0;
        tick();
        checks++; if (ProgCtr !== 10'h000 || PcWrap !== 1'b0) begin errors++; $display("[TB] FAIL branch_no_wrap got pc=%h wrap=%b expected pc=000 wrap=0", ProgCtr, PcWrap); end
        clearInputs();
    endtask

    task automatic test_back_to_back();
        LutWrEn = 1; LutWrAddr = 5'd7; LutWrData = 10'h055;
        tick();
        LutWrEn = 0;
        startAt(10'h100);
        LutWrEn = 1; LutWrAddr = 5'd7; LutWrData = 10'h0AA;
        BranchEn = 1; BranchTaken = 1; BranchIdx = 5'd7;
        tick();
        checks++; if (ProgCtr !== 10'h055) begin errors++; $display("[TB] FAIL same_cycle_write got %h expected 055", ProgCtr); end
        LutWrEn = 0;
        tick();
        checks++; if (ProgCtr !== 10'h0AA) begin errors++; $display("[TB] FAIL after_write got %h expected 0AA", ProgCtr); end
        clearInputs();
    endtask

    task automatic test_async_reset();
        tick();
        checks++; if (Fetching !== 1'b1 || CycleCnt === 16'd0) begin errors++; $display("[TB] FAIL pre_reset_run got fetch=%b cnt=%0d expected fetch=1 cnt>0", Fetching, CycleCnt); end
        #2;
        Reset = 0;
        #1;
        checks++; if (ProgCtr !== 10'h000 || Fetching !== 1'b0 || CycleCnt !== 16'd0 || Done !== 1'b0) begin errors++; $display("[TB] FAIL async_reset got pc=%h fetch=%b cnt=%0d done=%b expected pc=000 fetch=0 cnt=0 done=0", ProgCtr, Fetching, CycleCnt, Done); end
        tick();
        Reset = 1;
        startAt(10'h050);
        BranchEn = 1; BranchTaken = 1; BranchIdx = 5'd7;
        tick();
        checks++; if (ProgCtr !== 10'h000) begin errors++; $display("[TB] FAIL lut_cleared got %h expected 000", ProgCtr); end
        clearInputs();
    endtask

    initial begin
        $display("[TB] fetch_unit directed test start");
        test_reset();
        test_start_run();
        test_branch();
        test_ack_halt();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Program-counter and fetch-sequencing stage that sits directly upstream of the control decoder. It drives the instruction ROM address, loads the start address on Start, and advances or redirects the PC using the decoder's BranchEn/Ack and the ALU branch condition. Absolute branch targets come from a small writable branch LUT indexed by the instruction's low bits.

Parameters:
PC_W, 10, program counter / instruction ROM address width
LUT_AW, 5, branch LUT index width (2**LUT_AW entries)
CNT_W, 16, cycle counter width

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  level; while high, PC loads StartAddr and the block parks in LOAD
StartAddr  in  PC_W  program entry address
Ack  in  1  from Ctrl; current instruction is "done with program"
BranchEn  in  1  from Ctrl; current instruction is a branch
BranchTaken  in  1  ALU branch condition for the current instruction
BranchIdx  in  LUT_AW  LUT index, Instruction[LUT_AW-1:0]
Stall  in  1  hold PC (multi-cycle memory op)
LutWrEn  in  1  branch LUT write enable
LutWrAddr  in  LUT_AW  LUT write index
LutWrData  in  PC_W  LUT write data (absolute target)
ProgCtr  out  PC_W  instruction ROM address
Fetching  out  1  high in RUN
Done  out  1  high in HALT
PcWrap  out  1  one-cycle pulse when sequential increment wraps to 0
CycleCnt  out  CNT_W  RUN cycles since last load, saturating

Behaviour:
- Reset low (async): state=IDLE, ProgCtr=0, Done=0, Fetching=0, PcWrap=0, CycleCnt=0, all LUT entries=0.
- States: IDLE, LOAD, RUN, HALT. Fetching=(state==RUN); Done=(state==HALT). Both are registered-state decodes.
- Start=1 in any state (highest priority): next state=LOAD, ProgCtr<=StartAddr, CycleCnt<=0.
- LOAD with Start=0: next state=RUN; ProgCtr holds StartAddr. The first instruction is presented in the first RUN cycle.
- IDLE with Start=0: hold.
- RUN, evaluated in priority order each cycle:
  1. Ack=1: next state=HALT; ProgCtr holds.
  2. Stall=1: ProgCtr holds.
  3. BranchEn=1 and BranchTaken=1: ProgCtr<=LUT[BranchIdx].
  4. Otherwise (including BranchEn=1 with BranchTaken=0): ProgCtr<=ProgCtr+1, modulo 2**PC_W.
- Ack has priority over Stall and branch. BranchTaken is ignored when BranchEn=0.
- CycleCnt increments every RUN cycle, including stalled and Ack cycles, and saturates at all-ones.
- PcWrap=1 for exactly the cycle after a rule-4 increment from 2**PC_W-1 to 0. It is never set by a branch or a load.
- HALT: ProgCtr and CycleCnt hold; Done stays 1 until Start. Ack, BranchEn and Stall are ignored.
- BranchEn, BranchTaken, Ack and Stall are ignored outside RUN.
- Branch LUT:
  - Read is combinational.
  - Write is synchronous on Clk when LutWrEn=1, in any state.
  - A write and a branch read to the same index in one cycle: the branch uses the old value; the new value is visible next cycle.
- Reset asserted mid-RUN: immediate return to IDLE with reset values. LUT contents are lost.
- Latency: the PC update is visible one Clk after the decision cycle. The decoder sees the new instruction after ROM read latency, which is combinational in this design.

Decomposition:
- Shared package Definitions: fetch_state_t enum {IDLE, LOAD, RUN, HALT}; localparams PC_W, LUT_AW, CNT_W defaults.
- One sub-module, branch_lut: 2**LUT_AW x PC_W register array, async-clear on Reset, one sync write port, one comb read port.
- FSM, PC and counter live in fetch_unit.

Test Plan:
- Reset then Start=1 for 3 cycles with StartAddr=0x010, then Start=0 -> ProgCtr=0x010 in LOAD; RUN begins next cycle; ProgCtr sequence 0x010,0x011,0x012; Fetching=1.
- Write LUT[5]=0x123; in RUN at PC=0x020 drive BranchEn=1, BranchTaken=1, BranchIdx=5 -> next ProgCtr=0x123. Repeat with BranchTaken=0 -> 0x021.
- In RUN at PC=0x030 assert Ack together with BranchEn=1, BranchTaken=1, Stall=1 -> HALT, ProgCtr stays 0x030, Done=1 and holds for 10 cycles. Then Start=1 -> Done=0, state LOAD.
- Stall=1 for 4 cycles at PC=0x040 -> ProgCtr stays 0x040; CycleCnt advances by 4. Release -> 0x041.
- StartAddr=0x3FE, run 2 cycles -> ProgCtr 0x3FE,0x3FF,0x000; PcWrap pulses exactly once.
- Same-cycle LutWrEn to index 7 (0x0AA) with a branch via index 7 (old value 0x055) -> ProgCtr=0x055. A later branch via index 7 -> 0x0AA. Async Reset mid-RUN -> ProgCtr=0, IDLE, CycleCnt=0 without a clock edge.
